// File: rtl/gfx_pkg.sv
// Shared fixed-point types, constants and helpers for the geometry pipeline.
package gfx_pkg;

    localparam int WI     = 8;
    localparam int WF     = 8;
    localparam int GUARD  = 4;
    localparam int FXP_W  = WI + WF;
    localparam int PROD_W = 2 * FXP_W;
    localparam int ACC_W  = PROD_W + GUARD;

    typedef logic signed [FXP_W-1:0]  fxp_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam fxp_t FXP_ONE = fxp_t'(1 << WF);
    localparam fxp_t FXP_MAX = {1'b0, {(FXP_W-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(FXP_W-1){1'b0}}};

    typedef fxp_t mat4_t [16];

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DIV,
        DONE
    } pv_state_t;

    typedef struct packed {
        fxp_t value;
        logic sat;
    } fxp_rs_t;

    // Round half up at the WF boundary, then clamp to the signed fxp_t range.
    function automatic fxp_rs_t round_sat(input acc_t a);
        acc_t    rounded;
        acc_t    shifted;
        fxp_rs_t res;
        rounded   = a + (acc_t'(1) <<< (WF - 1));
        shifted   = rounded >>> WF;
        res.value = shifted[FXP_W-1:0];
        res.sat   = 1'b0;
        if (shifted > acc_t'(FXP_MAX)) begin
            res.value = FXP_MAX;
            res.sat   = 1'b1;
        end else if (shifted < acc_t'(FXP_MIN)) begin
            res.value = FXP_MIN;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/project_vertex_if.sv
// Vertex-in / NDC-out handshake bundle between vertex fetch, projection and raster.
interface project_vertex_if;
    import gfx_pkg::*;

    mat4_t matrix;
    fxp_t  in_x;
    fxp_t  in_y;
    fxp_t  in_z;
    logic  in_valid;
    logic  in_ready;
    fxp_t  out_x;
    fxp_t  out_y;
    fxp_t  out_z;
    logic  out_w_zero;
    logic  out_overflow;
    logic  out_valid;
    logic  out_ready;

    modport master (
        output matrix, in_x, in_y, in_z, in_valid, out_ready,
        input  in_ready, out_x, out_y, out_z, out_w_zero, out_overflow, out_valid
    );

    modport slave (
        input  matrix, in_x, in_y, in_z, in_valid, out_ready,
        output in_ready, out_x, out_y, out_z, out_w_zero, out_overflow, out_valid
    );

endinterface

// File: rtl/fxp_div.sv
// Combinational signed fixed-point divider: quo = num / den in the same Q format,
// optionally rounded half away from zero, saturated to the W-bit range.
module fxp_div #(
    parameter int W     = 16,
    parameter int WF    = 8,
    parameter bit ROUND = 1'b1
) (
    input  logic signed [W-1:0] num,
    input  logic signed [W-1:0] den,
    output logic signed [W-1:0] quo,
    output logic                sat,
    output logic                div_zero
);

    localparam int MW = W + WF + 1;
    localparam logic [MW-1:0] POS_LIM = MW'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [MW-1:0] NEG_LIM = MW'(64'd1 << (W - 1));

    logic [W-1:0]  num_abs;
    logic [W-1:0]  den_abs;
    logic [MW-1:0] dividend;
    logic [MW-1:0] divisor;
    logic [MW-1:0] q_mag;
    logic          neg;

    // Divide magnitudes, then restore the sign and clamp; a zero divisor yields 0.
    always_comb begin
        quo      = '0;
        sat      = 1'b0;
        div_zero = 1'b0;
        q_mag    = '0;
        neg      = num[W-1] ^ den[W-1];
        num_abs  = num[W-1] ? -num : num;
        den_abs  = den[W-1] ? -den : den;
        dividend = MW'(num_abs) << WF;
        divisor  = MW'(den_abs);
        if (ROUND) begin
            dividend = dividend + (divisor >> 1);
        end
        if (den == '0) begin
            div_zero = 1'b1;
        end else begin
            q_mag = dividend / divisor;
            if (!neg) begin
                if (q_mag > POS_LIM) begin
                    quo = {1'b0, {(W-1){1'b1}}};
                    sat = 1'b1;
                end else begin
                    quo = q_mag[W-1:0];
                end
            end else begin
                if (q_mag > NEG_LIM) begin
                    quo = {1'b1, {(W-1){1'b0}}};
                    sat = 1'b1;
                end else begin
                    quo = -q_mag[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/project_vertex.sv
// Projects one object-space vertex through a 4x4 matrix and divides by clip w.
// A single multiplier walks the 16 matrix elements, then one divider is reused
// for x, y and z; results are presented once and held until taken downstream.
module project_vertex (
    input  logic             clk,
    input  logic             rst_n,
    project_vertex_if.slave  pv
);
    import gfx_pkg::*;

    pv_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    acc_t       acc_q, acc_d;
    mat4_t      mat_q, mat_d;
    fxp_t       vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
    fxp_t       clip_q [4];
    fxp_t       clip_d [4];
    fxp_t       quo_q  [3];
    fxp_t       quo_d  [3];
    logic       ovf_q, ovf_d;
    logic       wz_q, wz_d;
    fxp_t       out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic       out_w_zero_q, out_w_zero_d;
    logic       out_overflow_q, out_overflow_d;
    logic       out_valid_q, out_valid_d;

    logic [1:0] row;
    logic [1:0] col;
    fxp_t       mul_a;
    fxp_t       mul_b;
    prod_t      prod;
    acc_t       acc_sum;
    fxp_rs_t    rs;
    fxp_t       div_quo;
    logic       div_sat;
    logic       div_zero;

    assign row = cnt_q[3:2];
    assign col = cnt_q[1:0];

    // Multiply one matrix element by the matching vertex component (w is 1.0) and accumulate the row.
    always_comb begin
        mul_a = mat_q[cnt_q];
        case (col)
            2'd0:    mul_b = vx_q;
            2'd1:    mul_b = vy_q;
            2'd2:    mul_b = vz_q;
            default: mul_b = FXP_ONE;
        endcase
        prod    = prod_t'(mul_a) * prod_t'(mul_b);
        acc_sum = (col == 2'd0) ? acc_t'(prod) : acc_q + acc_t'(prod);
        rs      = round_sat(acc_sum);
    end

    fxp_div #(
        .W     (FXP_W),
        .WF    (WF),
        .ROUND (1'b1)
    ) u_div (
        .num      (clip_q[col]),
        .den      (clip_q[3]),
        .quo      (div_quo),
        .sat      (div_sat),
        .div_zero (div_zero)
    );

    // Sequencing: accept, 16 MAC steps, 3 divides, then present the result until it is taken.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        mat_d          = mat_q;
        vx_d           = vx_q;
        vy_d           = vy_q;
        vz_d           = vz_q;
        clip_d         = clip_q;
        quo_d          = quo_q;
        ovf_d          = ovf_q;
        wz_d           = wz_q;
        out_x_d        = out_x_q;
        out_y_d        = out_y_q;
        out_z_d        = out_z_q;
        out_w_zero_d   = out_w_zero_q;
        out_overflow_d = out_overflow_q;
        out_valid_d    = out_valid_q;
        case (state_q)
            IDLE: begin
                if (pv.in_valid) begin
                    mat_d   = pv.matrix;
                    vx_d    = pv.in_x;
                    vy_d    = pv.in_y;
                    vz_d    = pv.in_z;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    wz_d    = 1'b0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                if (col == 2'd3) begin
                    clip_d[row] = rs.value;
                    ovf_d       = ovf_q | rs.sat;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                case (col)
                    2'd0:    quo_d[0] = div_quo;
                    2'd1:    quo_d[1] = div_quo;
                    default: quo_d[2] = div_quo;
                endcase
                ovf_d = ovf_q | div_sat;
                wz_d  = wz_q | div_zero;
                cnt_d = cnt_q + 4'd1;
                if (col == 2'd2) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                if (!out_valid_q) begin
                    out_x_d        = quo_q[0];
                    out_y_d        = quo_q[1];
                    out_z_d        = quo_q[2];
                    out_w_zero_d   = wz_q;
                    out_overflow_d = ovf_q;
                    out_valid_d    = 1'b1;
                end else if (pv.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // Control and output registers; reset drops any vertex in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            ovf_q          <= 1'b0;
            wz_q           <= 1'b0;
            out_x_q        <= '0;
            out_y_q        <= '0;
            out_z_q        <= '0;
            out_w_zero_q   <= 1'b0;
            out_overflow_q <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            ovf_q          <= ovf_d;
            wz_q           <= wz_d;
            out_x_q        <= out_x_d;
            out_y_q        <= out_y_d;
            out_z_q        <= out_z_d;
            out_w_zero_q   <= out_w_zero_d;
            out_overflow_q <= out_overflow_d;
            out_valid_q    <= out_valid_d;
        end
    end

    // Operand snapshot and intermediate clip/quotient storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q  <= '{default: '0};
            vx_q   <= '0;
            vy_q   <= '0;
            vz_q   <= '0;
            clip_q <= '{default: '0};
            quo_q  <= '{default: '0};
        end else begin
            mat_q  <= mat_d;
            vx_q   <= vx_d;
            vy_q   <= vy_d;
            vz_q   <= vz_d;
            clip_q <= clip_d;
            quo_q  <= quo_d;
        end
    end

    assign pv.in_ready     = (state_q == IDLE);
    assign pv.out_valid    = out_valid_q;
    assign pv.out_x        = out_x_q;
    assign pv.out_y        = out_y_q;
    assign pv.out_z        = out_z_q;
    assign pv.out_w_zero   = out_w_zero_q;
    assign pv.out_overflow = out_overflow_q;

endmodule

// File: tb/tb_project_vertex.sv
// Self-checking bench for project_vertex: directed cases plus randomized
// vertices compared against an arithmetic reference of the projection.
module tb_project_vertex;
    import gfx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    project_vertex_if pv ();

    project_vertex dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pv    (pv)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Clamp a value to the signed 16-bit fixed-point range, flagging any clamp.
    function automatic longint clamp16(input longint v, inout logic ov);
        if (v > 32767) begin
            ov = 1'b1;
            return 32767;
        end
        if (v < -32768) begin
            ov = 1'b1;
            return -32768;
        end
        return v;
    endfunction

    // Reference: clip = M*(x,y,z,1) rounded half up to Q8.8, then q = clip/w rounded half away from zero.
    function automatic void refModel(input mat4_t m, input fxp_t x, input fxp_t y, input fxp_t z,
                                     output fxp_t q [3], output logic wz, output logic ov);
        longint v [4];
        longint clip [4];
        longint s, num, mag, w;
        v[0] = longint'(x);
        v[1] = longint'(y);
        v[2] = longint'(z);
        v[3] = 256;
        ov = 1'b0;
        wz = 1'b0;
        for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int c = 0; c < 4; c++) s += longint'(m[r*4+c]) * v[c];
            s = (s + 128) >>> 8;
            clip[r] = clamp16(s, ov);
        end
        w = clip[3];
        for (int k = 0; k < 3; k++) begin
            if (w == 0) begin
                q[k] = '0;
                wz = 1'b1;
            end else begin
                num = clip[k] * 256;
                mag = ((num < 0 ? -num : num) + (w < 0 ? -w : w) / 2) / (w < 0 ? -w : w);
                s = ((num < 0) != (w < 0)) ? -mag : mag;
                q[k] = fxp_t'(clamp16(s, ov));
            end
        end
    endfunction

    function automatic fxp_t rndFxp(input int span);
        return fxp_t'(int'($urandom_range(0, 2 * span)) - span);
    endfunction

    // Present a vertex, complete the accept handshake, then scramble the inputs.
    task automatic driveAccept(input mat4_t m, input fxp_t x, input fxp_t y, input fxp_t z);
        int waitc = 0;
        @(negedge clk);
        while (!pv.in_ready && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        checkOutput("in_ready_idle", 32'(pv.in_ready), 32'd1);
        pv.matrix   = m;
        pv.in_x     = x;
        pv.in_y     = y;
        pv.in_z     = z;
        pv.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pv.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) pv.matrix[i] = fxp_t'($urandom);
        pv.in_x = fxp_t'($urandom);
        pv.in_y = fxp_t'($urandom);
        pv.in_z = fxp_t'($urandom);
    endtask

    // Run one vertex end to end with `hold` cycles of backpressure, checking against the model.
    task automatic applyStimulus(input mat4_t m, input fxp_t x, input fxp_t y, input fxp_t z, input int hold,
                                 output fxp_t ox, output fxp_t oy, output fxp_t oz,
                                 output logic owz, output logic oov);
        fxp_t eq [3];
        logic ewz, eov;
        int   lat;
        refModel(m, x, y, z, eq, ewz, eov);
        driveAccept(m, x, y, z);
        lat = 0;
        while (!pv.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd20);
        checkOutput("out_x", 32'(pv.out_x), 32'(eq[0]));
        checkOutput("out_y", 32'(pv.out_y), 32'(eq[1]));
        checkOutput("out_z", 32'(pv.out_z), 32'(eq[2]));
        checkOutput("out_w_zero", 32'(pv.out_w_zero), 32'(ewz));
        checkOutput("out_overflow", 32'(pv.out_overflow), 32'(eov));
        checkOutput("in_ready_busy", 32'(pv.in_ready), 32'd0);
        ox  = pv.out_x;
        oy  = pv.out_y;
        oz  = pv.out_z;
        owz = pv.out_w_zero;
        oov = pv.out_overflow;
        for (int i = 0; i < hold; i++) begin
            pv.in_valid = 1'b1;
            pv.in_x     = fxp_t'($urandom);
            @(negedge clk);
            checkOutput("hold_valid", 32'(pv.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(pv.in_ready), 32'd0);
            checkOutput("hold_x", 32'(pv.out_x), 32'(eq[0]));
            checkOutput("hold_z", 32'(pv.out_z), 32'(eq[2]));
        end
        pv.in_valid  = 1'b0;
        pv.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("valid_drop", 32'(pv.out_valid), 32'd0);
        checkOutput("ready_return", 32'(pv.in_ready), 32'd1);
        pv.out_ready = 1'b0;
    endtask

    mat4_t ident;
    mat4_t m;
    fxp_t  ox, oy, oz;
    logic  owz, oov;
    logic  seen_valid;

    initial begin
        for (int i = 0; i < 16; i++) ident[i] = (i % 5 == 0) ? FXP_ONE : fxp_t'(0);
        pv.matrix    = '{default: '0};
        pv.in_x      = '0;
        pv.in_y      = '0;
        pv.in_z      = '0;
        pv.in_valid  = 1'b0;
        pv.out_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(pv.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(pv.out_valid), 32'd0);
        checkOutput("rst_out_x", 32'(pv.out_x), 32'd0);
        checkOutput("rst_w_zero", 32'(pv.out_w_zero), 32'd0);
        checkOutput("rst_overflow", 32'(pv.out_overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] identity transform");
        applyStimulus(ident, 16'sh0100, 16'sh0200, 16'sh0300, 0, ox, oy, oz, owz, oov);
        checkOutput("id_x", 32'(ox), 32'(fxp_t'(16'h0100)));
        checkOutput("id_y", 32'(oy), 32'(fxp_t'(16'h0200)));
        checkOutput("id_z", 32'(oz), 32'(fxp_t'(16'h0300)));
        checkOutput("id_ovf", 32'(oov), 32'd0);

        $display("[TB] perspective w = z");
        m = ident;
        m[14] = FXP_ONE;
        m[15] = '0;
        applyStimulus(m, 16'sh0100, 16'sh0200, 16'sh0200, 0, ox, oy, oz, owz, oov);
        checkOutput("persp_x", 32'(ox), 32'(fxp_t'(16'h0080)));
        checkOutput("persp_y", 32'(oy), 32'(fxp_t'(16'h0100)));
        checkOutput("persp_z", 32'(oz), 32'(fxp_t'(16'h0100)));

        $display("[TB] backpressure");
        applyStimulus(ident, rndFxp(2048), rndFxp(2048), rndFxp(2048), 10, ox, oy, oz, owz, oov);

        $display("[TB] zero w");
        m = ident;
        m[15] = '0;
        applyStimulus(m, 16'sh0100, 16'sh0200, 16'sh0300, 0, ox, oy, oz, owz, oov);
        checkOutput("wz_x", 32'(ox), 32'd0);
        checkOutput("wz_flag", 32'(owz), 32'd1);
        checkOutput("wz_ovf", 32'(oov), 32'd0);

        $display("[TB] saturation");
        m = ident;
        m[0] = 16'sh7F00;
        applyStimulus(m, 16'sh7F00, 16'sh0000, 16'sh0000, 0, ox, oy, oz, owz, oov);
        checkOutput("satp_x", 32'(ox), 32'(fxp_t'(16'h7FFF)));
        checkOutput("satp_ovf", 32'(oov), 32'd1);
        m[0] = fxp_t'(16'h8100);
        applyStimulus(m, 16'sh7F00, 16'sh0000, 16'sh0000, 0, ox, oy, oz, owz, oov);
        checkOutput("satn_x", 32'(ox), 32'(fxp_t'(16'h8000)));
        checkOutput("satn_ovf", 32'(oov), 32'd1);

        $display("[TB] reset during MAC");
        driveAccept(ident, 16'sh0300, 16'sh0100, 16'sh0200);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (pv.out_valid) seen_valid = 1'b1;
        end
        checkOutput("abort_no_valid", 32'(seen_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(pv.in_ready), 32'd1);
        checkOutput("abort_out_x", 32'(pv.out_x), 32'd0);
        applyStimulus(ident, 16'sh0180, 16'shFE80, 16'sh0040, 0, ox, oy, oz, owz, oov);

        $display("[TB] randomized vertices");
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 16; i++) m[i] = rndFxp(512);
            if (n % 5 == 4) m[12] = '0;
            if (n % 5 == 4) m[13] = '0;
            if (n % 5 == 4) m[14] = '0;
            if (n % 5 == 4) m[15] = '0;
            applyStimulus(m, rndFxp(2048), rndFxp(2048), rndFxp(2048), int'($urandom_range(0, 3)),
                          ox, oy, oz, owz, oov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
